// File: rtl/ps2_kbd_decoder_if.sv
// PS/2 keyboard decoder bundle: raw PS/2 pins in, decoded key events out.
// Master drives the PS/2 pins, slave is the decoder.
interface ps2_kbd_decoder_if;
  logic       ps2_kbd_clk;
  logic       ps2_kbd_data;
  logic       key_strobe;
  logic [7:0] key_code;
  logic       key_pressed;
  logic       key_extended;
  logic [7:0] keys;
  logic       parity_err;
  logic       frame_err;

  modport master (
    output ps2_kbd_clk,
    output ps2_kbd_data,
    input  key_strobe,
    input  key_code,
    input  key_pressed,
    input  key_extended,
    input  keys,
    input  parity_err,
    input  frame_err
  );

  modport slave (
    input  ps2_kbd_clk,
    input  ps2_kbd_data,
    output key_strobe,
    output key_code,
    output key_pressed,
    output key_extended,
    output keys,
    output parity_err,
    output frame_err
  );
endinterface

// File: rtl/ps2_kbd_decoder.sv
// PS/2 set-2 keyboard decoder with E0/F0 prefixes and held-key vector.
// Optional mid-frame watchdog enabled by defining PS2_KBD_TIMEOUT_EN.
module ps2_kbd_decoder #(
  parameter int TIMEOUT_CYC = 2048
) (
  input logic            clk_sys,
  input logic            reset,
  ps2_kbd_decoder_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, DATA, PARITY, STOP, EVAL
  } state_t;

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 4094) begin : g_chk
    $error("TIMEOUT_CYC out of range");
  end

  state_t     state, state_n;
  logic [1:0] clk_sync, dat_sync;
  logic       clk_d;
  logic       fall, din;
  logic [2:0] bit_cnt;
  logic [7:0] sr;
  logic       par_bit, stop_bit;
  logic       rel, ext;
  logic [8:0] hk;
  logic       wd_to;

  logic       start, shift_en, par_ld, stop_ld, eval;
  logic       bad_stop, bad_par, ok;
  logic       is_f0, is_e0, is_e1;
  logic       do_strobe, do_perr, do_ferr;
  logic       set_rel, set_ext, clr_flags;

  logic       key_strobe_q, key_pressed_q, key_ext_q;
  logic       perr_q, ferr_q;
  logic [7:0] key_code_q;

  assign fall = clk_d & ~clk_sync[1];
  assign din  = dat_sync[1];

  // Two-flop synchronizers plus edge register on the PS/2 pins
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_d    <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], bus.ps2_kbd_clk};
      dat_sync <= {dat_sync[0], bus.ps2_kbd_data};
      clk_d    <= clk_sync[1];
    end
  end

`ifdef PS2_KBD_TIMEOUT_EN
  localparam logic [11:0] WD_LIM = 12'(TIMEOUT_CYC);
  logic [11:0] wd_cnt;

  // Watchdog: cycles since last PS/2 clock fall, saturating
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)
      wd_cnt <= '0;
    else if (fall)
      wd_cnt <= '0;
    else if (state != IDLE && wd_cnt != 12'hFFF)
      wd_cnt <= wd_cnt + 12'd1;
  end

  assign wd_to = (state != IDLE) && !fall && (wd_cnt >= WD_LIM);
`else
  assign wd_to = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic, one frame bit per clock fall
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (fall && !din)            state_n = DATA;
      DATA:    if (fall && bit_cnt == 3'd7) state_n = PARITY;
      PARITY:  if (fall)                    state_n = STOP;
      STOP:    if (fall)                    state_n = EVAL;
      EVAL:                                 state_n = IDLE;
      default:                              state_n = IDLE;
    endcase
    if (wd_to) state_n = IDLE;
  end

  // FSM control outputs
  always_comb begin
    start    = 1'b0;
    shift_en = 1'b0;
    par_ld   = 1'b0;
    stop_ld  = 1'b0;
    eval     = 1'b0;
    unique case (state)
      IDLE:    start    = fall & ~din;
      DATA:    shift_en = fall;
      PARITY:  par_ld   = fall;
      STOP:    stop_ld  = fall;
      EVAL:    eval     = 1'b1;
      default: ;
    endcase
  end

  // Frame evaluation: errors, prefixes, or a real scancode
  always_comb begin
    bad_stop  = ~stop_bit;
    bad_par   = ~(^{sr, par_bit});
    is_f0     = (sr == 8'hF0);
    is_e0     = (sr == 8'hE0);
    is_e1     = (sr == 8'hE1);
    ok        = eval & ~bad_stop & ~bad_par;
    do_ferr   = (eval & bad_stop) | wd_to;
    do_perr   = eval & ~bad_stop & bad_par;
    set_rel   = ok & is_f0;
    set_ext   = ok & is_e0;
    do_strobe = ok & ~is_f0 & ~is_e0 & ~is_e1;
    clr_flags = do_ferr | do_perr | do_strobe;
  end

  // Frame capture and prefix flags
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      bit_cnt  <= '0;
      sr       <= '0;
      par_bit  <= 1'b0;
      stop_bit <= 1'b0;
      rel      <= 1'b0;
      ext      <= 1'b0;
    end else begin
      if (start)         bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
      if (shift_en) sr       <= {din, sr[7:1]};
      if (par_ld)   par_bit  <= din;
      if (stop_ld)  stop_bit <= din;
      if (clr_flags) begin
        rel <= 1'b0;
        ext <= 1'b0;
      end else begin
        if (set_rel) rel <= 1'b1;
        if (set_ext) ext <= 1'b1;
      end
    end
  end

  // Event outputs and held-key tracking
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      key_strobe_q  <= 1'b0;
      key_code_q    <= '0;
      key_pressed_q <= 1'b0;
      key_ext_q     <= 1'b0;
      perr_q        <= 1'b0;
      ferr_q        <= 1'b0;
      hk            <= '0;
    end else begin
      key_strobe_q <= do_strobe;
      perr_q       <= do_perr;
      ferr_q       <= do_ferr;
      if (do_strobe) begin
        key_code_q    <= sr;
        key_pressed_q <= ~rel;
        key_ext_q     <= ext;
        case ({ext, sr})
          9'h174:  hk[0] <= ~rel;
          9'h16B:  hk[1] <= ~rel;
          9'h172:  hk[2] <= ~rel;
          9'h175:  hk[3] <= ~rel;
          9'h014:  hk[4] <= ~rel;
          9'h011:  hk[5] <= ~rel;
          9'h029:  hk[6] <= ~rel;
          9'h016:  hk[7] <= ~rel;
          9'h02E:  hk[8] <= ~rel;
          default: ;
        endcase
      end
    end
  end

  assign bus.key_strobe   = key_strobe_q;
  assign bus.key_code     = key_code_q;
  assign bus.key_pressed  = key_pressed_q;
  assign bus.key_extended = key_ext_q;
  assign bus.parity_err   = perr_q;
  assign bus.frame_err    = ferr_q;
  assign bus.keys = {hk[8], hk[7], hk[5] | hk[6], hk[4:0]};

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Scoreboard bench for ps2_kbd_decoder: directed frames, queued expectations.
// Build with PS2_KBD_TIMEOUT_EN to exercise the watchdog path.
module tb_ps2_kbd_decoder;

  localparam int HB = 8;

  typedef struct {
    logic [1:0] kind;
    logic [7:0] code;
    logic       pr;
    logic       ext;
    logic [7:0] keys;
    bit         lat;
  } ev_t;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   last_fall = 0;
  int   ferr_cnt  = 0;
  ev_t  sb[$];

  ps2_kbd_decoder_if ifc ();

  ps2_kbd_decoder #(.TIMEOUT_CYC(2048)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (ifc.slave)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc++;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Monitor: pop and compare whenever the DUT reports an event
  always @(negedge clk_sys) begin
    if (!reset &&
        (ifc.key_strobe || ifc.parity_err || ifc.frame_err)) begin
      ev_t e;
      logic [1:0] kind;
      if (ifc.frame_err) ferr_cnt++;
      kind = ifc.key_strobe ? 2'd0 : ifc.parity_err ? 2'd1 : 2'd2;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event s=%b p=%b f=%b code=%h",
                 ifc.key_strobe, ifc.parity_err, ifc.frame_err,
                 ifc.key_code);
      end else begin
        e = sb.pop_front();
        chk("event_kind", {30'd0, kind}, {30'd0, e.kind});
        chk("one_hot", {29'd0, ifc.key_strobe, ifc.parity_err,
            ifc.frame_err}, (32'd4 >> e.kind));
        chk("keys", {24'd0, ifc.keys}, {24'd0, e.keys});
        if (e.kind == 2'd0) begin
          chk("key_code", {24'd0, ifc.key_code}, {24'd0, e.code});
          chk("key_pressed", {31'd0, ifc.key_pressed}, {31'd0, e.pr});
          chk("key_extended", {31'd0, ifc.key_extended},
              {31'd0, e.ext});
        end
        if (e.lat)
          chk("latency", cyc - last_fall, 32'd4);
      end
    end
  end

  task automatic exp_s(input logic [7:0] c, input logic pr,
                       input logic ex, input logic [7:0] k);
    sb.push_back('{2'd0, c, pr, ex, k, 1'b1});
  endtask

  task automatic exp_p(input logic [7:0] k);
    sb.push_back('{2'd1, 8'h00, 1'b0, 1'b0, k, 1'b1});
  endtask

  task automatic exp_f(input logic [7:0] k, input bit lat);
    sb.push_back('{2'd2, 8'h00, 1'b0, 1'b0, k, lat});
  endtask

  task automatic ps2_bit(input logic b);
    ifc.ps2_kbd_data = b;
    repeat (HB) @(negedge clk_sys);
    ifc.ps2_kbd_clk = 1'b0;
    last_fall = cyc;
    repeat (HB) @(negedge clk_sys);
    ifc.ps2_kbd_clk = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input logic flip = 1'b0,
                      input logic stop = 1'b1);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ flip);
    ps2_bit(stop);
    ifc.ps2_kbd_data = 1'b1;
    repeat (HB) @(negedge clk_sys);
  endtask

  task automatic send_partial(input logic [7:0] b, input int n);
    ps2_bit(1'b0);
    for (int i = 0; i < n; i++) ps2_bit(b[i]);
    ifc.ps2_kbd_data = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    reset = 1'b1;
    ifc.ps2_kbd_clk  = 1'b1;
    ifc.ps2_kbd_data = 1'b1;
    repeat (4) @(negedge clk_sys);
    reset = 1'b0;
    repeat (4) @(negedge clk_sys);
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int f0;
    ifc.ps2_kbd_clk  = 1'b1;
    ifc.ps2_kbd_data = 1'b1;
    repeat (4) @(negedge clk_sys);
    chk("rst_strobe", {31'd0, ifc.key_strobe}, 32'd0);
    chk("rst_code", {24'd0, ifc.key_code}, 32'd0);
    chk("rst_pressed", {31'd0, ifc.key_pressed}, 32'd0);
    chk("rst_ext", {31'd0, ifc.key_extended}, 32'd0);
    chk("rst_keys", {24'd0, ifc.keys}, 32'd0);
    chk("rst_errs", {30'd0, ifc.parity_err, ifc.frame_err}, 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk_sys);

    // LCtrl press / release
    exp_s(8'h14, 1, 0, 8'h10); send(8'h14);
    send(8'hF0);
    exp_s(8'h14, 0, 0, 8'h00); send(8'h14);

    // Extended up vs keypad 8
    send(8'hE0);
    exp_s(8'h75, 1, 1, 8'h08); send(8'h75);
    exp_s(8'h75, 1, 0, 8'h08); send(8'h75);
    send(8'hE0); send(8'hF0);
    exp_s(8'h75, 0, 1, 8'h00); send(8'h75);

    // Parity error then good Space
    exp_p(8'h00); send(8'h29, 1'b1);
    exp_s(8'h29, 1, 0, 8'h20); send(8'h29);

    // F0 dropped by bad stop frame
    send(8'hF0);
    exp_f(8'h20, 1); send(8'h16, 1'b0, 1'b0);
    exp_s(8'h16, 1, 0, 8'h60); send(8'h16);

    // Double F0, F0 E0 on unheld key, E1 passthrough
    send(8'hF0); send(8'hF0);
    exp_s(8'h29, 0, 0, 8'h40); send(8'h29);
    send(8'hF0); send(8'hE0);
    exp_s(8'h74, 0, 1, 8'h40); send(8'h74);
    send(8'hE1);
    exp_s(8'h14, 1, 0, 8'h50); send(8'h14);

    // LAlt and Space tracked separately on keys[5]
    exp_s(8'h11, 1, 0, 8'h70); send(8'h11);
    exp_s(8'h29, 1, 0, 8'h70); send(8'h29);
    send(8'hF0);
    exp_s(8'h11, 0, 0, 8'h70); send(8'h11);
    send(8'hF0);
    exp_s(8'h29, 0, 0, 8'h50); send(8'h29);
    exp_s(8'h14, 1, 0, 8'h50); send(8'h14);

    // Partial frame left hanging
    f0 = ferr_cnt;
`ifdef PS2_KBD_TIMEOUT_EN
    exp_f(8'h50, 0);
    send_partial(8'h2E, 4);
    repeat (3000) @(negedge clk_sys);
    chk("timeout_ferr", ferr_cnt - f0, 32'd1);
    exp_s(8'h2E, 1, 0, 8'hD0); send(8'h2E);
    exp_s(8'h14, 1, 0, 8'hD0); send(8'h14);
    send(8'hE0);
    exp_s(8'h74, 1, 1, 8'hD1); send(8'h74);
    chk("held_keys", {24'd0, ifc.keys}, 32'hD1);
`else
    send_partial(8'h2E, 4);
    repeat (3000) @(negedge clk_sys);
    chk("no_timeout_ferr", ferr_cnt - f0, 32'd0);
    do_reset();
    chk("rst2_keys", {24'd0, ifc.keys}, 32'd0);
    exp_s(8'h2E, 1, 0, 8'h80); send(8'h2E);
    exp_s(8'h14, 1, 0, 8'h90); send(8'h14);
    send(8'hE0);
    exp_s(8'h74, 1, 1, 8'h91); send(8'h74);
    chk("held_keys", {24'd0, ifc.keys}, 32'h91);
`endif
    chk("sb_drained", sb.size(), 32'd0);

    // Reset mid-frame
    send_partial(8'h11, 3);
    @(negedge clk_sys);
    reset = 1'b1;
    repeat (2) @(negedge clk_sys);
    chk("mid_rst_keys", {24'd0, ifc.keys}, 32'd0);
    chk("mid_rst_code", {24'd0, ifc.key_code}, 32'd0);
    chk("mid_rst_flags", {28'd0, ifc.key_strobe, ifc.key_pressed,
        ifc.key_extended, ifc.parity_err | ifc.frame_err}, 32'd0);
    ifc.ps2_kbd_clk  = 1'b1;
    ifc.ps2_kbd_data = 1'b1;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    repeat (4) @(negedge clk_sys);
    exp_s(8'h11, 1, 0, 8'h20); send(8'h11);

    repeat (20) @(negedge clk_sys);
    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
